// File: rtl/axis_pkg.sv
// Shared types and the beat-generation function for the AXIS burst master.
// gen() works at a fixed wide width; callers truncate to their data width.
package axis_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [1:0] MODE_MUL   = 2'd0;
   localparam logic [1:0] MODE_ADD   = 2'd1;
   localparam logic [1:0] MODE_CONST = 2'd2;

   localparam int GEN_W = 64;

   // Low result bits depend only on low operand bits, so truncating later is exact modulo 2^W.
   function automatic logic [GEN_W-1:0] gen(input logic [GEN_W-1:0] seed,
                                            input logic [GEN_W-1:0] idx,
                                            input logic [1:0]       mode);
      case (mode)
         MODE_MUL:   gen = seed * idx;
         MODE_ADD:   gen = seed + idx;
         MODE_CONST: gen = seed;
         default:    gen = seed * idx;
      endcase
   endfunction

endpackage

// File: rtl/axis_beat_gen.sv
// Combinational beat generator: gen(seed, idx, mode) truncated to DATA_WIDTH.
// Index is zero-extended before the arithmetic; supports DATA_WIDTH up to 64.
module axis_beat_gen
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic [LEN_WIDTH-1:0]  idx_i,
   input  logic [1:0]            mode_i,
   output logic [DATA_WIDTH-1:0] beat_o
);

   assign beat_o = DATA_WIDTH'(gen(GEN_W'(seed_i), GEN_W'(idx_i), mode_i));

endmodule

// File: rtl/axis_burst_master.sv
// AXI4-Stream burst master: one start request emits len generated beats with
// registered outputs, no inter-beat bubbles, and an early-terminate abort.
module axis_burst_master
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  m_axis_clk,
   input  logic                  m_axis_rstn,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [1:0]            mode,
   input  logic                  abort,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [1:0]            mode_q, mode_d;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d;
   logic                  abort_pend_q, abort_pend_d;
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tlast_q, tlast_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  hs;
   logic                  abort_hit;
   logic [LEN_WIDTH-1:0]  idx_nxt;
   logic [DATA_WIDTH-1:0] gen_seed;
   logic [LEN_WIDTH-1:0]  gen_idx;
   logic [1:0]            gen_mode;
   logic [DATA_WIDTH-1:0] beat;

   assign hs        = tvalid_q & m_axis_tready;
   assign abort_hit = abort_pend_q | abort;
   assign idx_nxt   = idx_q + LEN_WIDTH'(1);

   // One generator serves both the first beat (from live inputs) and every following beat.
   always_comb begin
      gen_seed = seed_q;
      gen_idx  = idx_nxt;
      gen_mode = mode_q;
      if (state_q == IDLE) begin
         gen_seed = din;
         gen_idx  = '0;
         gen_mode = mode;
      end
   end

   axis_beat_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_beat_gen (
      .seed_i (gen_seed),
      .idx_i  (gen_idx),
      .mode_i (gen_mode),
      .beat_o (beat)
   );

   always_comb begin
      state_d      = state_q;
      seed_d       = seed_q;
      len_d        = len_q;
      mode_d       = mode_q;
      idx_d        = idx_q;
      abort_pend_d = abort_pend_q;
      tvalid_d     = tvalid_q;
      tdata_d      = tdata_q;
      tlast_d      = tlast_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            abort_pend_d = 1'b0;
            if (start) begin
               if (len == '0) begin
                  err_d = 1'b1;
               end else begin
                  seed_d   = din;
                  len_d    = len;
                  mode_d   = mode;
                  idx_d    = '0;
                  tvalid_d = 1'b1;
                  tdata_d  = beat;
                  tlast_d  = (len == LEN_WIDTH'(1));
                  state_d  = SEND;
               end
            end
         end
         SEND: begin
            if (hs) begin
               if (tlast_q) begin
                  tvalid_d     = 1'b0;
                  tlast_d      = 1'b0;
                  tdata_d      = '0;
                  done_d       = 1'b1;
                  abort_pend_d = 1'b0;
                  state_d      = IDLE;
               end else begin
                  idx_d        = idx_nxt;
                  tdata_d      = beat;
                  tlast_d      = (idx_nxt == len_q - LEN_WIDTH'(1)) | abort_hit;
                  abort_pend_d = 1'b0;
               end
            end else if (abort && !tlast_q) begin
               abort_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_axis_clk) begin
      if (!m_axis_rstn) begin
         state_q      <= IDLE;
         seed_q       <= '0;
         len_q        <= '0;
         mode_q       <= '0;
         idx_q        <= '0;
         abort_pend_q <= 1'b0;
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
         tlast_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         seed_q       <= seed_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         idx_q        <= idx_d;
         abort_pend_q <= abort_pend_d;
         tvalid_q     <= tvalid_d;
         tdata_q      <= tdata_d;
         tlast_q      <= tlast_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = (state_q == SEND);
   assign done          = done_q;
   assign err           = err_q;

   // A stalled beat must stay presented unchanged until it is taken.
   property p_axis_hold;
      @(posedge m_axis_clk) disable iff (!m_axis_rstn)
         (m_axis_tvalid && !m_axis_tready) |=>
            (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast));
   endproperty
   a_axis_hold: assert property (p_axis_hold);

endmodule

// File: tb/tb_axis_burst_master.sv
// Directed self-checking bench for axis_burst_master (DATA_WIDTH=8, LEN_WIDTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_burst_master;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] din;
   logic       start;
   logic [3:0] len;
   logic [1:0] mode;
   logic       abort;
   logic       tready;
   logic       m_axis_tvalid;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tlast;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_burst_master #(
      .DATA_WIDTH (8),
      .LEN_WIDTH  (4)
   ) dut (
      .m_axis_clk    (clk),
      .m_axis_rstn   (rstn),
      .din           (din),
      .start         (start),
      .len           (len),
      .mode          (mode),
      .abort         (abort),
      .m_axis_tready (tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   task automatic test_reset();
      logic [12:0] got;
      rstn = 1'b0; din = 8'h0; start = 1'b0; len = 4'd0; mode = 2'd0; abort = 1'b0; tready = 1'b0;
      repeat (2) @(negedge clk);
      got = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done, err};
      checks++;
      if (got !== 13'h0) $display("FAIL reset outputs: got %h expected 0000", got);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, m_axis_tvalid} !== 2'b00) $display("FAIL reset idle: got busy=%b tvalid=%b expected 0 0", busy, m_axis_tvalid);
      if (got !== 13'h0) errors++;
      if ({busy, m_axis_tvalid} !== 2'b00) errors++;
   endtask

   task automatic test_basic();
      logic [7:0] exp [4] = '{8'd0, 8'd3, 8'd6, 8'd9};
      logic [10:0] got, want;
      din = 8'd3; len = 4'd4; mode = 2'd0; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata};
         want = {1'b1, (i == 3), 1'b1, exp[i]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL basic beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
      got  = {m_axis_tvalid, m_axis_tlast, busy, done, 7'd0};
      want = {4'b0001, 7'd0};
      checks++;
      if (got !== want || m_axis_tdata !== 8'd0) begin
         errors++;
         $display("FAIL basic done: got v/l/busy/done %h data %h expected %h data 00", got, m_axis_tdata, want);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic done pulse width: got %b expected 0", done);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [5] = '{8'd5, 8'd6, 8'd6, 8'd6, 8'd7};
      logic       exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] got, want;
      int hs_cnt = 0;
      din = 8'd5; len = 4'd3; mode = 2'd1; start = 1'b1; tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, exp_l[k], exp_d[k]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL bp cycle %0d: got %h expected %h", k, got, want);
         end
         tready = pat[k];
         if (m_axis_tvalid && tready) hs_cnt++;
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || hs_cnt != 3) begin
         errors++;
         $display("FAIL bp end: got done=%b handshakes=%0d expected 1 3", done, hs_cnt);
      end
   endtask

   task automatic test_wrap_and_restart();
      logic [7:0] exp_a [3] = '{8'h00, 8'hFF, 8'hFE};
      logic [9:0] got, want;
      din = 8'hFF; len = 4'd3; mode = 2'd0; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 2), exp_a[i]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL wrap beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
      checks++;
      if ({done, busy, m_axis_tvalid} !== 3'b100) begin
         errors++;
         $display("FAIL wrap done: got done/busy/tvalid %b expected 100", {done, busy, m_axis_tvalid});
      end
      din = 8'hFF; len = 4'd2; mode = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 1), 8'hFF};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL const beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL const done: got %b expected 1", done);
      end
   endtask

   task automatic test_abort();
      logic [9:0] got, want;
      int hs_cnt = 0;
      logic [7:0] exp_d [4] = '{8'd2, 8'd2, 8'd2, 8'd3};
      logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       pat_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic       pat_a [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      din = 8'd1; len = 4'd8; mode = 2'd0; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 3), 8'(i)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL abort beat %0d: got %h expected %h", i, got, want);
         end
         abort = (i == 2);
         if (m_axis_tvalid && tready) hs_cnt++;
         @(negedge clk);
      end
      abort = 1'b0;
      checks++;
      if ({done, busy} !== 2'b10 || hs_cnt != 4) begin
         errors++;
         $display("FAIL abort end: got done/busy %b handshakes %0d expected 10 4", {done, busy}, hs_cnt);
      end
      din = 8'd2; len = 4'd8; mode = 2'd1; start = 1'b1; tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, exp_l[k], exp_d[k]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL abort stalled cycle %0d: got %h expected %h", k, got, want);
         end
         tready = pat_r[k];
         abort  = pat_a[k];
         @(negedge clk);
      end
      abort = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL abort stalled done: got %b expected 1", done);
      end
   endtask

   task automatic test_len_zero_and_busy_start();
      logic [9:0] got, want;
      din = 8'd7; len = 4'd0; mode = 2'd0; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({err, busy, m_axis_tvalid} !== 3'b100) begin
         errors++;
         $display("FAIL len0: got err/busy/tvalid %b expected 100", {err, busy, m_axis_tvalid});
      end
      @(negedge clk);
      checks++;
      if ({err, busy, m_axis_tvalid} !== 3'b000) begin
         errors++;
         $display("FAIL len0 after: got err/busy/tvalid %b expected 000", {err, busy, m_axis_tvalid});
      end
      din = 8'd2; len = 4'd3; mode = 2'd1; start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 2), 8'(2 + i)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL busy-start beat %0d: got %h expected %h", i, got, want);
         end
         start = (i == 0);
         din   = (i == 0) ? 8'd9 : 8'd0;
         len   = (i == 0) ? 4'd1 : 4'd0;
         mode  = 2'd2;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if ({done, err} !== 2'b10) begin
         errors++;
         $display("FAIL busy-start done: got done/err %b expected 10", {done, err});
      end
      @(negedge clk);
      checks++;
      if ({m_axis_tvalid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL busy-start idle: got tvalid/busy %b expected 00", {m_axis_tvalid, busy});
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [12:0] all;
      logic [9:0]  got, want;
      din = 8'd4; len = 4'd3; mode = 2'd0; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'd4}) begin
         errors++;
         $display("FAIL rst beat1: got %h expected 104", {m_axis_tvalid, m_axis_tdata});
      end
      rstn = 1'b0;
      @(negedge clk);
      all = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done, err};
      checks++;
      if (all !== 13'h0) begin
         errors++;
         $display("FAIL rst mid-burst: got %h expected 0000", all);
      end
      rstn = 1'b1;
      @(negedge clk);
      din = 8'd4; len = 4'd2; mode = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 1), 8'(4 + i)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL rst restart beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_max_len_and_mode3();
      logic [9:0] got, want;
      din = 8'd1; len = 4'd15; mode = 2'd1; start = 1'b1; tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 14), 8'(i + 1)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL maxlen beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL maxlen done: got done/busy %b expected 10", {done, busy});
      end
      din = 8'd2; len = 4'd3; mode = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         got  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         want = {1'b1, (i == 2), 8'(2 * i)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL mode3 beat %0d: got %h expected %h", i, got, want);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap_and_restart();
      test_abort();
      test_len_zero_and_busy_start();
      test_reset_mid_burst();
      test_max_len_and_mode3();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
